sipo_deserializer: RTL and testbench

Serial-in/parallel-out deserializer. It is the receive-side counterpart of the team's PISO serializer in the I2C IP common library. It collects SIZE_DATA_OUT/SIZE_DATA_IN narrow beats, qualified by i_valid, into one parallel word and flags completion with a one-cycle strobe. The I2C shift engine uses it to assemble received address and data bytes from SDA samples.

---
 rtl/sipo_deserializer_if.sv | 29 ++
 rtl/sipo_deserializer.sv | 106 ++++++++++
 tb/tb_sipo_deserializer.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sipo_deserializer_if.sv
// Bus bundle between a serial beat source and the SIPO deserializer.
interface sipo_deserializer_if #(
  parameter int unsigned SIZE_DATA_IN  = 1,
  parameter int unsigned SIZE_DATA_OUT = 8
);
  localparam int unsigned DEPTH = SIZE_DATA_OUT / SIZE_DATA_IN;
  localparam int unsigned CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic                     i_start;
  logic                     i_valid;
  logic [SIZE_DATA_IN-1:0]  i_data;
  logic [SIZE_DATA_OUT-1:0] o_data;
  logic                     o_valid;
  logic                     o_busy;
  logic                     o_abort;
  logic [CNT_W-1:0]         o_count;

  // Beat source side
  modport master (
    output i_start, i_valid, i_data,
    input  o_data, o_valid, o_busy, o_abort, o_count
  );

  // Deserializer side
  modport slave (
    input  i_start, i_valid, i_data,
    output o_data, o_valid, o_busy, o_abort, o_count
  );
endinterface

// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out deserializer: assembles DEPTH narrow beats into one word.
module sipo_deserializer #(
  parameter int unsigned SIZE_DATA_IN  = 1,
  parameter int unsigned SIZE_DATA_OUT = 8,
  parameter int unsigned MSB_FIRST     = 1
) (
  input logic                i_clk,
  input logic                i_rst_n,
  sipo_deserializer_if.slave bus
);
  localparam int unsigned DEPTH = SIZE_DATA_OUT / SIZE_DATA_IN;
  localparam int unsigned CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned POS_W = (SIZE_DATA_OUT > 1) ? $clog2(SIZE_DATA_OUT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                   r_state, w_state_nxt;
  logic [SIZE_DATA_OUT-1:0] r_shift, w_shift_nxt;
  logic [SIZE_DATA_OUT-1:0] r_data,  w_data_nxt;
  logic [CNT_W-1:0]         r_count, w_count_nxt;
  logic                     r_valid, w_valid_nxt;
  logic                     r_abort, w_abort_nxt;

  logic                     w_accept;
  logic [CNT_W-1:0]         w_slot;
  logic [POS_W-1:0]         w_pos;
  logic [SIZE_DATA_OUT-1:0] w_base;
  logic [SIZE_DATA_OUT-1:0] w_beat;
  logic [SIZE_DATA_OUT-1:0] w_word;

  // A beat is only taken while the frame is enabled
  assign w_accept = bus.i_start & bus.i_valid;

  // Slice position of the incoming beat; a fresh word starts from an empty register
  assign w_slot = (MSB_FIRST != 0) ? (LAST - r_count) : r_count;
  assign w_pos  = POS_W'(w_slot) * POS_W'(SIZE_DATA_IN);
  assign w_base = (r_state == SHIFT) ? r_shift : '0;
  assign w_beat = SIZE_DATA_OUT'(bus.i_data) << w_pos;
  assign w_word = w_base | w_beat;

  // Next-state and next-register values
  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_count_nxt = r_count;
    w_data_nxt  = r_data;
    w_valid_nxt = 1'b0;
    w_abort_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_shift_nxt = w_word;
          w_count_nxt = CNT_W'(1);
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (!bus.i_start) begin
          w_shift_nxt = '0;
          w_count_nxt = '0;
          w_abort_nxt = 1'b1;
          w_state_nxt = IDLE;
        end else if (bus.i_valid) begin
          if (r_count == LAST) begin
            w_data_nxt  = w_word;
            w_valid_nxt = 1'b1;
            w_shift_nxt = '0;
            w_count_nxt = '0;
            w_state_nxt = IDLE;
          end else begin
            w_shift_nxt = w_word;
            w_count_nxt = r_count + CNT_W'(1);
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_data  <= '0;
      r_count <= '0;
      r_valid <= 1'b0;
      r_abort <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_data  <= w_data_nxt;
      r_count <= w_count_nxt;
      r_valid <= w_valid_nxt;
      r_abort <= w_abort_nxt;
    end
  end

  assign bus.o_data  = r_data;
  assign bus.o_valid = r_valid;
  assign bus.o_busy  = (r_state == SHIFT);
  assign bus.o_abort = r_abort;
  assign bus.o_count = r_count;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Randomized scoreboard bench for sipo_deserializer (8x1 MSB-first and 8x2 LSB-first).
module tb_sipo_deserializer;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sipo_deserializer_if #(.SIZE_DATA_IN(1), .SIZE_DATA_OUT(8))  ifa ();
  sipo_deserializer_if #(.SIZE_DATA_IN(2), .SIZE_DATA_OUT(16)) ifb ();

  sipo_deserializer #(.SIZE_DATA_IN(1), .SIZE_DATA_OUT(8), .MSB_FIRST(1)) u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .bus(ifa)
  );
  sipo_deserializer #(.SIZE_DATA_IN(2), .SIZE_DATA_OUT(16), .MSB_FIRST(0)) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .bus(ifb)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_qa[$];
  logic [31:0] exp_qb[$];
  int          abort_qa[$];
  logic [31:0] beats_a[$];
  logic [31:0] beats_b[$];
  time         vt_qa[$];
  logic [31:0] held_a = 32'h0;
  logic [31:0] held_b = 32'h0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endfunction

  // Reference model A: 8 one-bit beats, first beat becomes the MSB
  task automatic model_a(input logic s, input logic v, input logic d);
    logic [31:0] w;
    if (s && v) begin
      beats_a.push_back(32'(d));
      if (beats_a.size() == 8) begin
        w = 32'h0;
        foreach (beats_a[k]) w = (w << 1) | beats_a[k];
        exp_qa.push_back(w);
        beats_a.delete();
      end
    end else if (!s && beats_a.size() != 0) begin
      abort_qa.push_back(1);
      beats_a.delete();
    end
  endtask

  // Reference model B: 8 two-bit beats, beat k weighted by 4**k
  task automatic model_b(input logic s, input logic v, input logic [1:0] d);
    logic [31:0] w;
    if (s && v) begin
      beats_b.push_back(32'(d));
      if (beats_b.size() == 8) begin
        w = 32'h0;
        foreach (beats_b[k]) w = w + beats_b[k] * (32'd1 << (2 * k));
        exp_qb.push_back(w);
        beats_b.delete();
      end
    end else if (!s) begin
      beats_b.delete();
    end
  endtask

  task automatic drive_a(input logic s, input logic v, input logic d);
    @(posedge clk);
    #1;
    ifa.i_start = s;
    ifa.i_valid = v;
    ifa.i_data  = d;
    model_a(s, v, d);
  endtask

  task automatic drive_b(input logic s, input logic v, input logic [1:0] d);
    @(posedge clk);
    #1;
    ifb.i_start = s;
    ifb.i_valid = v;
    ifb.i_data  = d;
    model_b(s, v, d);
  endtask

  task automatic word_a(input logic [7:0] w, input int gap_max);
    logic [7:0] t;
    t = w;
    for (int k = 0; k < 8; k++) begin
      repeat ($urandom_range(gap_max, 0)) drive_a(1'b1, 1'b0, 1'($urandom));
      drive_a(1'b1, 1'b1, t[7-k]);
    end
  endtask

  task automatic idle_a(input int n);
    repeat (n) drive_a(1'b0, 1'($urandom), 1'($urandom));
  endtask

  // Monitor A: pops expected words/aborts whenever the DUT strobes
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held_a = 32'h0;
      end else begin
        if (ifa.o_valid) begin
          vt_qa.push_back($time);
          if (exp_qa.size() == 0) begin
            check("a_valid_unexpected", 32'(ifa.o_valid), 32'h0);
          end else begin
            e = exp_qa.pop_front();
            check("a_word", 32'(ifa.o_data), e);
            check("a_busy_on_valid", 32'(ifa.o_busy), 32'h0);
            check("a_count_on_valid", 32'(ifa.o_count), 32'h0);
            held_a = e;
          end
        end else begin
          check("a_data_hold", 32'(ifa.o_data), held_a);
        end
        if (ifa.o_abort) begin
          if (abort_qa.size() == 0) begin
            check("a_abort_unexpected", 32'(ifa.o_abort), 32'h0);
          end else begin
            void'(abort_qa.pop_front());
            check("a_valid_on_abort", 32'(ifa.o_valid), 32'h0);
          end
        end
      end
    end
  end

  // Monitor B
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held_b = 32'h0;
      end else if (ifb.o_valid) begin
        if (exp_qb.size() == 0) begin
          check("b_valid_unexpected", 32'(ifb.o_valid), 32'h0);
        end else begin
          e = exp_qb.pop_front();
          check("b_word", 32'(ifb.o_data), e);
          held_b = e;
        end
      end else begin
        check("b_data_hold", 32'(ifb.o_data), held_b);
        check("b_no_abort", 32'(ifb.o_abort), 32'h0);
      end
    end
  end

  initial begin
    logic [7:0] a5;
    logic [1:0] bseq [8];
    rst_n       = 1'b0;
    ifa.i_start = 1'b0; ifa.i_valid = 1'b0; ifa.i_data = '0;
    ifb.i_start = 1'b0; ifb.i_valid = 1'b0; ifb.i_data = '0;
    #12;
    check("rst_data",  32'(ifa.o_data),  32'h0);
    check("rst_valid", 32'(ifa.o_valid), 32'h0);
    check("rst_busy",  32'(ifa.o_busy),  32'h0);
    check("rst_abort", 32'(ifa.o_abort), 32'h0);
    check("rst_count", 32'(ifa.o_count), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Plain A5 stream
    word_a(8'hA5, 0);
    idle_a(3);

    // A5 with two-cycle gaps after beats 3 and 6; count must hold
    a5 = 8'hA5;
    for (int k = 0; k < 8; k++) begin
      if (k == 3 || k == 6) begin
        repeat (2) begin
          drive_a(1'b1, 1'b0, 1'($urandom));
          check("gap_count_hold", 32'(ifa.o_count), 32'(k));
          check("gap_busy", 32'(ifa.o_busy), 32'h1);
        end
      end
      drive_a(1'b1, 1'b1, a5[7-k]);
    end
    idle_a(3);

    // Back-to-back A5, 3C: strobes 8 cycles apart
    vt_qa.delete();
    word_a(8'hA5, 0);
    word_a(8'h3C, 0);
    idle_a(5);
    check("b2b_pulses", 32'(vt_qa.size()), 32'd2);
    if (vt_qa.size() == 2) check("b2b_spacing", 32'(vt_qa[1] - vt_qa[0]), 32'd80);
    check("b2b_held", 32'(ifa.o_data), 32'h3C);

    // Abort after 3 beats, then a fresh word
    drive_a(1'b1, 1'b1, 1'b1);
    drive_a(1'b1, 1'b1, 1'b0);
    drive_a(1'b1, 1'b1, 1'b1);
    drive_a(1'b0, 1'b1, 1'b1);
    check("abort_state_count", 32'(ifa.o_count), 32'd3);
    idle_a(2);
    check("abort_drained", 32'(abort_qa.size()), 32'h0);
    word_a(8'hC3, 1);
    idle_a(2);

    // Asynchronous reset mid-word
    for (int k = 0; k < 5; k++) drive_a(1'b1, 1'b1, 1'($urandom));
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    beats_a.delete();
    ifa.i_start = 1'b0; ifa.i_valid = 1'b0;
    #1;
    check("arst_data",  32'(ifa.o_data),  32'h0);
    check("arst_busy",  32'(ifa.o_busy),  32'h0);
    check("arst_count", 32'(ifa.o_count), 32'h0);
    check("arst_valid", 32'(ifa.o_valid), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    word_a(8'h5A, 0);
    idle_a(2);

    // Random words with gaps and occasional aborts
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(3, 0) == 0) begin
        repeat ($urandom_range(7, 1)) drive_a(1'b1, 1'b1, 1'($urandom));
        drive_a(1'b0, 1'($urandom), 1'($urandom));
      end
      word_a(8'($urandom), 2);
      if ($urandom_range(1, 0) == 0) idle_a($urandom_range(2, 1));
    end
    idle_a(4);
    check("a_words_drained", 32'(exp_qa.size()), 32'h0);
    check("a_aborts_drained", 32'(abort_qa.size()), 32'h0);

    // 2-bit LSB-first: 1,2,3,0,1,2,3,0 -> 16'h3939
    bseq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    for (int k = 0; k < 8; k++) drive_b(1'b1, 1'b1, bseq[k]);
    drive_b(1'b0, 1'b0, 2'd0);
    @(negedge clk);
    check("b_3939", 32'(ifb.o_data), 32'h3939);
    for (int n = 0; n < 10; n++) begin
      for (int k = 0; k < 8; k++) begin
        if ($urandom_range(2, 0) == 0) drive_b(1'b1, 1'b0, 2'($urandom));
        drive_b(1'b1, 1'b1, 2'($urandom));
      end
    end
    repeat (3) drive_b(1'b0, 1'b0, 2'd0);
    check("b_words_drained", 32'(exp_qb.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
